shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Command-driven controller that sequences the 16-bit register-file/shifter datapath (reg_shifter) one operation at a time. It accepts one command per valid/ready handshake: load, multi-bit shift left, multi-bit shift right, or read. It converts each command into the per-cycle wr/shift/address/data controls the datapath needs, then returns the final register value with a one-cycle done pulse. It sits between a host/control FSM and a reg_shifter instance and is that datapath's only master for wr, shift and rd_addr_a.

Parameters:
WIDTH, 16, datapath word width; must match reg_shifter.
ADDR_W, 3, register address width (8 registers).
AMT_W, 4, shift amount width; maximum shift count is 2^AMT_W-1 (15).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-low reset; sampled on clk.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command; high only in IDLE.
cmd_op  in  2  00 load, 01 shift left, 10 shift right, 11 read.
cmd_reg  in  ADDR_W  target register.
cmd_amt  in  AMT_W  shift count; used only by ops 01 and 10.
cmd_data  in  WIDTH  load value; used only by op 00.
busy  out  1  high while not IDLE.
done  out  1  one-cycle pulse when the command completes.
result  out  WIDTH  target register value after the command; held until the next done.
rs_wr  out  1  to reg_shifter wr.
rs_shift  out  1  to reg_shifter shift.
rs_shift_dir  out  1  to reg_shifter shift_dir; 0 left, 1 right.
rs_rd_addr_a  out  ADDR_W  to reg_shifter rd_addr_a.
rs_wr_addr  out  ADDR_W  to reg_shifter wr_addr.
rs_d_in  out  WIDTH  to reg_shifter d_in.
rs_d_out_a  in  WIDTH  from reg_shifter d_out_a; combinational read of rs_rd_addr_a.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state goes to IDLE; done, result, busy, rs_wr, rs_shift, rs_shift_dir, rs_rd_addr_a, rs_wr_addr, rs_d_in all 0.
  - cmd_ready is 1 from the first cycle after reset is released.
- Reset mid-operation aborts immediately; no further wr/shift is issued. Register contents already written are not restored.
- States: IDLE, LOAD, SHIFT, CAPT.
- IDLE: cmd_ready=1, busy=0, all rs_* strobes 0.
  - On cmd_valid && cmd_ready, latch op, reg, amt and data, load counter cnt<=cmd_amt, then:
    - op 00 -> LOAD.
    - op 01/10 with amt!=0 -> SHIFT.
    - op 01/10 with amt==0, or op 11 -> CAPT.
- LOAD (1 cycle): rs_wr=1, rs_wr_addr=reg, rs_d_in=data, rs_shift=0 -> CAPT.
- SHIFT (amt cycles): rs_shift=1, rs_shift_dir=op[1], rs_rd_addr_a=reg, rs_wr_addr=reg, rs_wr=0.
  - The register updates once per cycle; cnt decrements each cycle.
  - When cnt==1, go to CAPT.
- CAPT (1 cycle): rs_rd_addr_a=reg, no strobes. At the edge, result<=rs_d_out_a and done<=1 for exactly one cycle; next state IDLE.
- Latency from accept edge to done high: load 3 cycles; shift N (N>=1) N+2 cycles; shift 0 or read 2 cycles.
- done is high during the first IDLE cycle. A new command may be accepted in that same cycle (back-to-back allowed).
- Invariants:
  - rs_wr and rs_shift are never both 1.
  - Strobes are registered or state-decoded with no glitches across states.
  - rs_rd_addr_a equals the latched reg in SHIFT and CAPT, and 0 in IDLE.
- cmd_valid while busy is ignored (cmd_ready=0). Latched fields are unaffected by input changes after acceptance.
- Shift semantics are logical, zero-fill, one bit per cycle. Bits shifted out are lost; there is no wrap-around.

Test Plan:
- Reset, then load R3=0x00F0 -> rs_wr high for exactly 1 cycle with wr_addr=3; done 3 cycles after accept; result=0x00F0.
- Then shift left R3 by 4 -> rs_shift high 4 consecutive cycles, dir=0, rd_addr_a=3; done 6 cycles after accept; result=0x0F00.
- Load R1=0x8001, shift right by 3 -> result=0x1000. Load R2=0xC000, shift left by 1 -> result=0x8000 (MSB lost).
- Shift R3 by amt=0, and read R3 -> no wr/shift strobes; done 2 cycles after accept; result equals the current R3 value (0x0F00).
- cmd_valid held high with a different command while busy -> not accepted. A back-to-back command presented in the done cycle is accepted.
- Load R5=0x0001, shift left by 8, drive reset=0 after the 3rd shift cycle -> next cycle all rs_* strobes 0 and done=0. After release, cmd_ready=1 and result=0.

Source files
------------

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command sequencer driving a reg_shifter datapath.
// Turns load/shift/read commands into per-cycle register-file strobes and returns the result.
module shift_sequencer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int AMT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_reg,
  input  logic [AMT_W-1:0]  cmd_amt,
  input  logic [WIDTH-1:0]  cmd_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              rs_wr,
  output logic              rs_shift,
  output logic              rs_shift_dir,
  output logic [ADDR_W-1:0] rs_rd_addr_a,
  output logic [ADDR_W-1:0] rs_wr_addr,
  output logic [WIDTH-1:0]  rs_d_in,
  input  logic [WIDTH-1:0]  rs_d_out_a
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, CAPT} state_e;

  state_e              state_q, state_d;
  logic                dir_q, dir_d;
  logic [ADDR_W-1:0]   reg_q, reg_d;
  logic [AMT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                done_q, done_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      reg_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      reg_q    <= reg_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    reg_d        = reg_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    result_d     = result_q;
    done_d       = 1'b0;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    rs_wr        = 1'b0;
    rs_shift     = 1'b0;
    rs_shift_dir = 1'b0;
    rs_rd_addr_a = '0;
    rs_wr_addr   = '0;
    rs_d_in      = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          dir_d  = cmd_op[1];
          reg_d  = cmd_reg;
          cnt_d  = cmd_amt;
          data_d = cmd_data;
          if (cmd_op == 2'b00) begin
            state_d = LOAD;
          end else if (cmd_op != 2'b11 && cmd_amt != '0) begin
            state_d = SHIFT;
          end else begin
            state_d = CAPT;
          end
        end
      end
      LOAD: begin
        rs_wr      = 1'b1;
        rs_wr_addr = reg_q;
        rs_d_in    = data_q;
        state_d    = CAPT;
      end
      SHIFT: begin
        // One bit per cycle; the datapath shifts the register addressed by wr_addr in place.
        rs_shift     = 1'b1;
        rs_shift_dir = dir_q;
        rs_rd_addr_a = reg_q;
        rs_wr_addr   = reg_q;
        cnt_d        = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        rs_rd_addr_a = reg_q;
        result_d     = rs_d_out_a;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed bench for shift_sequencer with a behavioural register file.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_reg;
  logic [3:0]  cmd_amt;
  logic [15:0] cmd_data;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        rs_wr;
  logic        rs_shift;
  logic        rs_shift_dir;
  logic [2:0]  rs_rd_addr_a;
  logic [2:0]  rs_wr_addr;
  logic [15:0] rs_d_in;
  logic [15:0] rs_d_out_a;

  logic [15:0] regs [8];
  logic        clear_regs;

  int pass_cnt = 0;
  int total = 0;
  int both_err = 0;
  int ready_err = 0;
  int idle_err = 0;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
    .busy(busy), .done(done), .result(result),
    .rs_wr(rs_wr), .rs_shift(rs_shift), .rs_shift_dir(rs_shift_dir),
    .rs_rd_addr_a(rs_rd_addr_a), .rs_wr_addr(rs_wr_addr),
    .rs_d_in(rs_d_in), .rs_d_out_a(rs_d_out_a)
  );

  // Reference register file: write has priority, logical zero-fill shifts.
  assign rs_d_out_a = regs[rs_rd_addr_a];
  always @(posedge clk) begin
    if (clear_regs) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
    end else if (rs_wr) begin
      regs[rs_wr_addr] <= rs_d_in;
    end else if (rs_shift) begin
      regs[rs_wr_addr] <= rs_shift_dir ? (regs[rs_wr_addr] >> 1) : (regs[rs_wr_addr] << 1);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (rs_wr && rs_shift) both_err++;
      if (busy && cmd_ready) ready_err++;
      if (!busy && (rs_rd_addr_a != 3'd0 || rs_wr || rs_shift)) idle_err++;
    end
  end

  // Issues one command from a negedge and returns at the negedge where done is seen.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] r, input logic [3:0] amt,
                         input logic [15:0] d, input bit hold,
                         output int lat, output int nwr, output int nsh, output int bad,
                         output logic [15:0] res);
    cmd_valid = 1'b1; cmd_op = op; cmd_reg = r; cmd_amt = amt; cmd_data = d;
    @(posedge clk); #1;
    if (hold) begin
      cmd_op = 2'b11; cmd_reg = 3'd0; cmd_amt = 4'hF; cmd_data = 16'hFFFF;
    end else begin
      cmd_valid = 1'b0; cmd_op = ~op; cmd_reg = ~r; cmd_amt = ~amt; cmd_data = ~d;
    end
    lat = 1; nwr = 0; nsh = 0; bad = 0;
    @(negedge clk);
    while (!done && lat < 40) begin
      if (rs_wr) begin
        nwr++;
        if (rs_wr_addr !== r || rs_d_in !== d) bad++;
      end else if (rs_shift) begin
        nsh++;
        if (rs_shift_dir !== op[1] || rs_rd_addr_a !== r || rs_wr_addr !== r) bad++;
      end else if (rs_rd_addr_a !== r) begin
        bad++;
      end
      @(posedge clk); lat++;
      @(negedge clk);
    end
    res = result;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear_regs = 1'b1; cmd_valid = 1'b0;
    cmd_op = 2'b00; cmd_reg = 3'd0; cmd_amt = 4'd0; cmd_data = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; clear_regs = 1'b0;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total++; if (result !== 16'h0000) $display("FAIL reset_result got %h want 0000", result); else pass_cnt++;
    total++;
    if ({rs_wr, rs_shift, rs_shift_dir, rs_rd_addr_a, rs_wr_addr, rs_d_in} !== 25'd0)
      $display("FAIL reset_strobes got %b%b%b %h %h %h want all 0", rs_wr, rs_shift, rs_shift_dir,
               rs_rd_addr_a, rs_wr_addr, rs_d_in);
    else pass_cnt++;
  endtask

  task automatic test_load_shift_left();
    int lat, nwr, nsh, bad; logic [15:0] res;
    run_cmd(2'b00, 3'd3, 4'd0, 16'h00F0, 1'b0, lat, nwr, nsh, bad, res);
    total++; if (lat != 3) $display("FAIL load_latency got %0d want 3", lat); else pass_cnt++;
    total++; if (nwr != 1 || nsh != 0) $display("FAIL load_strobes got wr=%0d sh=%0d want 1/0", nwr, nsh); else pass_cnt++;
    total++; if (bad != 0) $display("FAIL load_ctl got %0d bad cycles want 0", bad); else pass_cnt++;
    total++; if (res !== 16'h00F0) $display("FAIL load_result got %h want 00f0", res); else pass_cnt++;
    run_cmd(2'b01, 3'd3, 4'd4, 16'h0000, 1'b0, lat, nwr, nsh, bad, res);
    total++; if (lat != 6) $display("FAIL shl4_latency got %0d want 6", lat); else pass_cnt++;
    total++; if (nwr != 0 || nsh != 4) $display("FAIL shl4_strobes got wr=%0d sh=%0d want 0/4", nwr, nsh); else pass_cnt++;
    total++; if (bad != 0) $display("FAIL shl4_ctl got %0d bad cycles want 0", bad); else pass_cnt++;
    total++; if (res !== 16'h0F00) $display("FAIL shl4_result got %h want 0f00", res); else pass_cnt++;
  endtask

  task automatic test_shift_right();
    int lat, nwr, nsh, bad; logic [15:0] res;
    run_cmd(2'b00, 3'd1, 4'd0, 16'h8001, 1'b0, lat, nwr, nsh, bad, res);
    total++; if (res !== 16'h8001) $display("FAIL load_r1 got %h want 8001", res); else pass_cnt++;
    run_cmd(2'b10, 3'd1, 4'd3, 16'h0000, 1'b0, lat, nwr, nsh, bad, res);
    total++; if (lat != 5) $display("FAIL shr3_latency got %0d want 5", lat); else pass_cnt++;
    total++; if (nsh != 3 || bad != 0) $display("FAIL shr3_ctl got sh=%0d bad=%0d want 3/0", nsh, bad); else pass_cnt++;
    total++; if (res !== 16'h1000) $display("FAIL shr3_result got %h want 1000", res); else pass_cnt++;
  endtask

  task automatic test_msb_lost();
    int lat, nwr, nsh, bad; logic [15:0] res;
    run_cmd(2'b00, 3'd2, 4'd0, 16'hC000, 1'b0, lat, nwr, nsh, bad, res);
    run_cmd(2'b01, 3'd2, 4'd1, 16'h0000, 1'b0, lat, nwr, nsh, bad, res);
    total++; if (lat != 3) $display("FAIL shl1_latency got %0d want 3", lat); else pass_cnt++;
    total++; if (res !== 16'h8000) $display("FAIL shl1_result got %h want 8000", res); else pass_cnt++;
  endtask

  task automatic test_zero_and_read();
    int lat, nwr, nsh, bad; logic [15:0] res;
    run_cmd(2'b01, 3'd3, 4'd0, 16'h0000, 1'b0, lat, nwr, nsh, bad, res);
    total++; if (lat != 2) $display("FAIL shl0_latency got %0d want 2", lat); else pass_cnt++;
    total++; if (nwr != 0 || nsh != 0) $display("FAIL shl0_strobes got wr=%0d sh=%0d want 0/0", nwr, nsh); else pass_cnt++;
    total++; if (res !== 16'h0F00) $display("FAIL shl0_result got %h want 0f00", res); else pass_cnt++;
    run_cmd(2'b11, 3'd3, 4'd7, 16'hAAAA, 1'b0, lat, nwr, nsh, bad, res);
    total++; if (lat != 2) $display("FAIL read_latency got %0d want 2", lat); else pass_cnt++;
    total++; if (nwr != 0 || nsh != 0 || bad != 0) $display("FAIL read_strobes got wr=%0d sh=%0d bad=%0d want 0", nwr, nsh, bad); else pass_cnt++;
    total++; if (res !== 16'h0F00) $display("FAIL read_result got %h want 0f00", res); else pass_cnt++;
  endtask

  task automatic test_busy_and_back_to_back();
    int lat, nwr, nsh, bad; logic [15:0] res;
    run_cmd(2'b00, 3'd0, 4'd0, 16'h1234, 1'b0, lat, nwr, nsh, bad, res);
    run_cmd(2'b10, 3'd1, 4'd2, 16'h0000, 1'b1, lat, nwr, nsh, bad, res);
    total++; if (lat != 4) $display("FAIL busy_latency got %0d want 4", lat); else pass_cnt++;
    total++; if (nsh != 2 || bad != 0) $display("FAIL busy_ctl got sh=%0d bad=%0d want 2/0", nsh, bad); else pass_cnt++;
    total++; if (res !== 16'h0400) $display("FAIL busy_result got %h want 0400", res); else pass_cnt++;
    total++; if (cmd_ready !== 1'b1) $display("FAIL done_cycle_ready got %b want 1", cmd_ready); else pass_cnt++;
    run_cmd(2'b11, 3'd0, 4'd0, 16'h0000, 1'b0, lat, nwr, nsh, bad, res);
    total++; if (lat != 2) $display("FAIL b2b_latency got %0d want 2", lat); else pass_cnt++;
    total++; if (res !== 16'h1234) $display("FAIL b2b_result got %h want 1234", res); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int lat, nwr, nsh, bad; logic [15:0] res;
    run_cmd(2'b00, 3'd5, 4'd0, 16'h0001, 1'b0, lat, nwr, nsh, bad, res);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_reg = 3'd5; cmd_amt = 4'd8; cmd_data = 16'h0000;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (rs_shift !== 1'b1) $display("FAIL abort_in_shift got %b want 1", rs_shift); else pass_cnt++;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({rs_wr, rs_shift, rs_shift_dir, rs_rd_addr_a, rs_wr_addr, rs_d_in, done} !== 26'd0)
      $display("FAIL abort_strobes got wr=%b sh=%b dir=%b rd=%h wa=%h d=%h done=%b want all 0",
               rs_wr, rs_shift, rs_shift_dir, rs_rd_addr_a, rs_wr_addr, rs_d_in, done);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", cmd_ready); else pass_cnt++;
    total++; if (result !== 16'h0000) $display("FAIL abort_result got %h want 0000", result); else pass_cnt++;
    run_cmd(2'b11, 3'd5, 4'd0, 16'h0000, 1'b0, lat, nwr, nsh, bad, res);
    total++; if (res !== 16'h0008) $display("FAIL abort_r5 got %h want 0008", res); else pass_cnt++;
  endtask

  task automatic test_invariants();
    total++; if (both_err != 0) $display("FAIL wr_and_shift got %0d cycles want 0", both_err); else pass_cnt++;
    total++; if (ready_err != 0) $display("FAIL ready_while_busy got %0d cycles want 0", ready_err); else pass_cnt++;
    total++; if (idle_err != 0) $display("FAIL idle_outputs got %0d cycles want 0", idle_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_shift_left();
    test_shift_right();
    test_msb_lost();
    test_zero_and_read();
    test_busy_and_back_to_back();
    test_reset_abort();
    test_invariants();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
